// File: rtl/ag6502_phase_gen.sv
// Two-phase clock and bus-cycle generator for the ag6502 core: phi_0/phi_1/phi_2
// from a fast base clock, with wait-state stretching, wait timeout and single-step/halt.
module ag6502_phase_gen #(
    parameter int PH0_LO   = 5,
    parameter int PH0_HI   = 5,
    parameter int DELAY1   = 2,
    parameter int DELAY2   = 1,
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             baseclk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             wait_req,
    output logic             phi_0,
    output logic             phi_1,
    output logic             phi_2,
    output logic             cyc_start,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic             halted,
    output logic             wait_timeout,
    output logic [1:0]       dbg_state
);
    localparam int PH_MAX = (PH0_LO > PH0_HI) ? PH0_LO : PH0_HI;
    localparam int PW     = $clog2(PH_MAX);
    localparam int WW     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam int HW     = DELAY1 + DELAY2;
    localparam logic [PW-1:0] LO_LAST   = PW'(PH0_LO - 1);
    localparam logic [PW-1:0] HI_LAST   = PW'(PH0_HI - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'((MAX_WAIT == 0) ? 0 : MAX_WAIT - 1);

    if (PH0_LO < 2) begin : g_chk_lo
        $error("PH0_LO must be at least 2");
    end
    if (PH0_HI < 2) begin : g_chk_hi
        $error("PH0_HI must be at least 2");
    end
    if (DELAY1 < 1 || DELAY1 >= PH0_LO) begin : g_chk_d1
        $error("DELAY1 must satisfy 1 <= DELAY1 < PH0_LO");
    end
    if (DELAY2 < 0 || DELAY2 >= DELAY1 || HW >= PH0_HI) begin : g_chk_d2
        $error("DELAY2 must satisfy 0 <= DELAY2 < DELAY1 and DELAY1+DELAY2 < PH0_HI");
    end
    if (MAX_WAIT < 0 || CNT_W < 1) begin : g_chk_misc
        $error("MAX_WAIT must be >= 0 and CNT_W >= 1");
    end

    typedef enum logic [1:0] {S_LOW = 2'd0, S_HIGH = 2'd1, S_WAIT = 2'd2} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic             pend_q, pend_d;
    logic             phi_0_q, phi_1_q, phi_2_q;
    logic             phi_0_d, phi_1_d, phi_2_d;
    logic             cs_q, cs_d;
    logic             to_q, to_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [HW-1:0]    h_q, h_d;
    logic [HW:0]      ext;
    logic             go;

    assign go = run | pend_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        pend_d  = pend_q;
        cs_d    = 1'b0;
        to_d    = 1'b0;
        cyc_d   = cyc_q;
        unique case (state_q)
            S_LOW: begin
                if (cnt_q == LO_LAST) begin
                    if (go) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                        pend_d  = 1'b0;
                        cs_d    = 1'b1;
                        cyc_d   = cyc_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            S_HIGH: begin
                if (cnt_q == HI_LAST) begin
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    state_d = wait_req ? S_WAIT : S_LOW;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            S_WAIT: begin
                if (!wait_req) begin
                    state_d = S_LOW;
                end else if (MAX_WAIT != 0 && wcnt_q == WAIT_LAST) begin
                    state_d = S_LOW;
                    to_d    = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            default: state_d = S_LOW;
        endcase
        // A step arriving in the very cycle a grant is consumed is folded into that grant.
        if (step && !run && !cs_d) begin
            pend_d = 1'b1;
        end
    end

    // ext[k] is phi_0 as it will be k cycles before the next edge's cycle.
    assign phi_0_d = (state_d != S_LOW);
    assign ext     = {h_q, phi_0_d};
    assign phi_1_d = ~ext[DELAY1];
    assign phi_2_d = ext[DELAY2] & ext[HW];
    assign h_d     = ext[HW-1:0];

    always_ff @(posedge baseclk) begin
        if (rst) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            pend_q  <= 1'b0;
            phi_0_q <= 1'b0;
            phi_1_q <= 1'b1;
            phi_2_q <= 1'b0;
            cs_q    <= 1'b0;
            to_q    <= 1'b0;
            cyc_q   <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            pend_q  <= pend_d;
            phi_0_q <= phi_0_d;
            phi_1_q <= phi_1_d;
            phi_2_q <= phi_2_d;
            cs_q    <= cs_d;
            to_q    <= to_d;
            cyc_q   <= cyc_d;
            h_q     <= h_d;
        end
    end

    assign phi_0        = phi_0_q;
    assign phi_1        = phi_1_q;
    assign phi_2        = phi_2_q;
    assign cyc_start    = cs_q;
    assign cyc_cnt      = cyc_q;
    assign wait_timeout = to_q;
    assign halted       = (state_q == S_LOW) && (cnt_q == LO_LAST) && !go;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_ag6502_phase_gen.sv
// Bench for ag6502_phase_gen: phase-age reference model with an expected queue,
// directed scenarios with pinned cycle numbers, then randomized run/step/wait/reset.
module tb_ag6502_phase_gen;
    localparam int LO = 5;
    localparam int HI = 5;
    localparam int D1 = 2;
    localparam int D2 = 1;
    localparam int MW = 16;

    logic baseclk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic step = 1'b0;
    logic wait_req = 1'b0;

    logic        phi_0, phi_1, phi_2, cyc_start, halted, wait_timeout;
    logic [15:0] cyc_cnt;
    logic [1:0]  dbg_state;
    logic        p0_4, p1_4, p2_4, cs_4, halt_4, to_4;
    logic [3:0]  cnt_4;
    logic [1:0]  dbg_4;

    ag6502_phase_gen dut (
        .baseclk(baseclk), .rst(rst), .run(run), .step(step), .wait_req(wait_req),
        .phi_0(phi_0), .phi_1(phi_1), .phi_2(phi_2), .cyc_start(cyc_start),
        .cyc_cnt(cyc_cnt), .halted(halted), .wait_timeout(wait_timeout),
        .dbg_state(dbg_state)
    );

    ag6502_phase_gen #(.CNT_W(4)) dut4 (
        .baseclk(baseclk), .rst(rst), .run(run), .step(step), .wait_req(wait_req),
        .phi_0(p0_4), .phi_1(p1_4), .phi_2(p2_4), .cyc_start(cs_4),
        .cyc_cnt(cnt_4), .halted(halt_4), .wait_timeout(to_4),
        .dbg_state(dbg_4)
    );

    always #5 baseclk = ~baseclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: phi_0 history plus the age of the current phase.
    bit          mh[0:15];
    int          m_age;
    bit          m_pend, m_cs, m_to;
    int unsigned m_cnt;
    int          rc;
    logic [20:0] exp_q[$];
    bit          s5_done;
    int          r_mode;

    function automatic logic [20:0] pack_exp();
        logic [31:0] c;
        c = m_cnt;
        return {mh[0], ~mh[D1], mh[D2] & mh[D1+D2], m_cs, m_to, c[15:0]};
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 16; j++) mh[j] = 1'b0;
        m_age = 0; m_pend = 0; m_cs = 0; m_to = 0; m_cnt = 0; rc = 0;
    endtask

    task automatic model_step();
        bit p0n, csn, ton;
        int agen;
        if (rst) begin
            model_reset();
        end else begin
            p0n = mh[0]; agen = m_age + 1; csn = 0; ton = 0;
            if (!mh[0]) begin
                if (m_age >= LO - 1 && (run || m_pend)) begin
                    p0n = 1; agen = 0; csn = 1; m_cnt++; m_pend = 0;
                end else if (step && !run) begin
                    m_pend = 1;
                end
            end else begin
                if (step && !run) m_pend = 1;
                if (m_age == HI - 1 && !wait_req) begin
                    p0n = 0; agen = 0;
                end else if (m_age >= HI) begin
                    if (!wait_req) begin
                        p0n = 0; agen = 0;
                    end else if (MW != 0 && m_age - HI == MW - 1) begin
                        p0n = 0; agen = 0; ton = 1;
                    end
                end
            end
            for (int j = 15; j > 0; j--) mh[j] = mh[j-1];
            mh[0] = p0n; m_age = agen; m_cs = csn; m_to = ton; rc++;
        end
        exp_q.push_back(pack_exp());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, rc, act, exp);
        end
    endtask

    task automatic compare_all();
        logic [20:0] e;
        logic        e_halt;
        if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty at cycle %0d: got 0 entries, expected 1", rc);
        end else begin
            e = exp_q.pop_front();
            e_halt = !mh[0] && (m_age >= LO - 1) && !run && !m_pend;
            chk("phi_0", phi_0, e[20]);
            chk("phi_1", phi_1, e[19]);
            chk("phi_2", phi_2, e[18]);
            chk("cyc_start", cyc_start, e[17]);
            chk("wait_timeout", wait_timeout, e[16]);
            chk("cyc_cnt", cyc_cnt, e[15:0]);
            chk("halted", halted, e_halt);
            chk("no_overlap", phi_1 & phi_2, 0);
            chk("w4_phi_0", p0_4, e[20]);
            chk("w4_cyc_cnt", cnt_4, e[3:0]);
        end
    endtask

    task automatic cycle(input bit cmp);
        if (cmp) compare_all();
        else if (exp_q.size() > 0) void'(exp_q.pop_front());
        @(posedge baseclk);
        model_step();
        @(negedge baseclk);
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0; wait_req = 1'b0;
        #1; cycle(1);
        #1; cycle(1);
        rst = 1'b0;
    endtask

    task automatic drive(input int scn);
        rst = 1'b0; run = 1'b1; step = 1'b0; wait_req = 1'b0;
        case (scn)
            2: wait_req = (rc >= 8 && rc <= 13);
            3: wait_req = 1'b1;
            4: begin
                run  = 1'b0;
                step = (rc == 19 || rc == 20);
            end
            5: begin
                wait_req = !s5_done && rc >= 8;
                if (!s5_done && rc == 12) begin
                    rst = 1'b1; s5_done = 1'b1;
                end
            end
            7: begin
                if (rc % 50 == 0) r_mode = $urandom_range(0, 2);
                run = (r_mode == 0) ? 1'b1 : (r_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                step = ($urandom_range(0, 9) == 0);
                wait_req = ($urandom_range(0, 2) == 0);
                rst = ($urandom_range(0, 299) == 0);
            end
            default: ;
        endcase
    endtask

    task automatic pins(input int scn);
        case (scn)
            1: begin
                if (rc == 0) begin
                    chk("s1_rst_phi0", phi_0, 0); chk("s1_rst_phi1", phi_1, 1);
                    chk("s1_rst_phi2", phi_2, 0); chk("s1_rst_cnt", cyc_cnt, 0);
                end
                if (rc == 4)  chk("s1_phi0_pre", phi_0, 0);
                if (rc == 5) begin
                    chk("s1_phi0_rise", phi_0, 1); chk("s1_cs5", cyc_start, 1);
                    chk("s1_cnt5", cyc_cnt, 1);
                end
                if (rc == 6)  begin chk("s1_cs6", cyc_start, 0); chk("s1_phi1_6", phi_1, 1); end
                if (rc == 7)  begin chk("s1_phi1_fall", phi_1, 0); chk("s1_phi2_7", phi_2, 0); end
                if (rc == 8)  chk("s1_phi2_rise", phi_2, 1);
                if (rc == 10) chk("s1_phi0_fall", phi_0, 0);
                if (rc == 11) begin chk("s1_phi2_fall", phi_2, 0); chk("s1_phi1_11", phi_1, 0); end
                if (rc == 12) chk("s1_phi1_rise", phi_1, 1);
                if (rc == 15) begin chk("s1_cs15", cyc_start, 1); chk("s1_cnt15", cyc_cnt, 2); end
            end
            2: begin
                if (rc == 14) chk("s2_phi0_14", phi_0, 1);
                if (rc == 15) begin
                    chk("s2_phi0_fall", phi_0, 0); chk("s2_phi2_15", phi_2, 1);
                    chk("s2_to", wait_timeout, 0);
                end
                if (rc == 16) begin chk("s2_phi2_fall", phi_2, 0); chk("s2_phi1_16", phi_1, 0); end
                if (rc == 17) chk("s2_phi1_rise", phi_1, 1);
                if (rc == 20) chk("s2_cs20", cyc_start, 1);
            end
            3: begin
                if (rc == 25) chk("s3_phi0_25", phi_0, 1);
                if (rc == 26) begin chk("s3_phi0_fall", phi_0, 0); chk("s3_to26", wait_timeout, 1); end
                if (rc == 27) chk("s3_to27", wait_timeout, 0);
                if (rc == 31) chk("s3_cs31", cyc_start, 1);
                if (rc == 57) chk("s3_cs57", cyc_start, 1);
            end
            4: begin
                if (rc == 3)  chk("s4_halt3", halted, 0);
                if (rc == 4)  chk("s4_halt4", halted, 1);
                if (rc == 20) begin chk("s4_phi0_20", phi_0, 0); chk("s4_halt20", halted, 0); end
                if (rc == 21) chk("s4_phi0_21", phi_0, 1);
                if (rc == 25) chk("s4_phi0_25", phi_0, 1);
                if (rc == 26) chk("s4_phi0_26", phi_0, 0);
                if (rc == 30) chk("s4_halt30", halted, 1);
                if (rc == 40) begin chk("s4_cnt", cyc_cnt, 1); chk("s4_phi0_40", phi_0, 0); end
            end
            5: begin
                if (!s5_done && rc == 11) begin
                    chk("s5_pre_phi2", phi_2, 1); chk("s5_pre_phi1", phi_1, 0);
                end
                if (s5_done && rc == 0) begin
                    chk("s5_rst_phi0", phi_0, 0); chk("s5_rst_phi1", phi_1, 1);
                    chk("s5_rst_phi2", phi_2, 0); chk("s5_rst_cnt", cyc_cnt, 0);
                end
                if (s5_done && rc == 7) chk("s5_phi2_7", phi_2, 0);
                if (s5_done && rc == 5) chk("s5_phi0_5", phi_0, 1);
                if (s5_done && rc == 8) chk("s5_phi2_8", phi_2, 1);
            end
            6: begin
                if (rc == 145) chk("s6_cnt4_15", cnt_4, 15);
                if (rc == 155) begin chk("s6_cnt4_wrap", cnt_4, 0); chk("s6_cs155", cs_4, 1); end
                if (rc == 165) begin chk("s6_cnt4_1", cnt_4, 1); chk("s6_cnt16", cyc_cnt, 17); end
            end
            default: ;
        endcase
    endtask

    task automatic run_scn(input int scn, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            drive(scn);
            #1;
            pins(scn);
            cycle(1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        s5_done = 1'b0;
        r_mode = 0;
        exp_q.push_back(pack_exp());
        #1; cycle(0);
        #1; cycle(0);

        do_reset(); run_scn(1, 40);
        do_reset(); run_scn(2, 40);
        do_reset(); run_scn(3, 80);
        do_reset(); run_scn(4, 45);
        do_reset(); run_scn(5, 50);
        do_reset(); run_scn(6, 170);
        do_reset(); run_scn(7, 800);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
